lfsr_rng_fifo: RTL and testbench
================================

LFSR_RNG_FIFO -- requirements
Module: lfsr_rng_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning FIFO depth in 32-bit words; legal values are powers of two from 2 to 8.
REQ-002 The block SHALL have port clk, input, width 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port resetn, input, width 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port lfsr_data, input, width 32, the upstream LFSR word.
REQ-005 The block SHALL have port lfsr_valid, input, width 1, meaning lfsr_data is valid.
REQ-006 The block SHALL have port lfsr_ready, output, width 1, meaning the FIFO accepts a word this cycle.
REQ-007 The block SHALL have port reg_ctrl_we, input, width 4, the byte write enables for the control register.
REQ-008 The block SHALL have port reg_ctrl_di, input, width 32, the control write data.
REQ-009 The block SHALL have port reg_ctrl_do, output, width 32, the control and status readback.
REQ-010 The block SHALL have port reg_dat_re, input, width 1, the CPU read request for a random word.
REQ-011 The block SHALL have port reg_dat_do, output, width 32, the random word returned.
REQ-012 The block SHALL have port reg_dat_wait, output, width 1, the stall for the CPU read.

Function
REQ-013 Control bit 0 SHALL be ENABLE (R/W, written via byte 0).
REQ-014 Control bit 1 SHALL be FLUSH, write-1 self-clearing, and SHALL always read back 0.
REQ-015 Control bit 2 SHALL be HERR, sticky, write-1-to-clear.
REQ-016 Control bits [7:4] SHALL be COUNT (read-only), holding an occupancy of 0..DEPTH.
REQ-017 All other control bits SHALL read 0 and ignore writes.
REQ-018 lfsr_ready SHALL equal ENABLE && !full && !flush_this_cycle, combinationally.
REQ-019 A push SHALL occur on every edge where lfsr_valid && lfsr_ready.
REQ-020 A pushed word SHALL be readable from the next cycle onward, giving 1-cycle push-to-read latency.
REQ-021 reg_dat_wait SHALL equal reg_dat_re && empty, combinationally.
REQ-022 reg_dat_do SHALL show the head word when the FIFO is non-empty, and 32'h0000_0000 when empty.
REQ-023 A pop SHALL occur on every edge where reg_dat_re && !empty.
REQ-024 The CPU SHALL hold reg_dat_re high through wait cycles; the block SHALL return the first word pushed once the stall ends.
REQ-025 A push and a pop in the same cycle SHALL leave COUNT unchanged.
REQ-026 A push to an empty FIFO and a read in the same cycle SHALL produce wait=1 with no pop that cycle.
REQ-027 When full, lfsr_ready SHALL be 0 and no word SHALL be dropped or overwritten.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be derived from a (log2(DEPTH)+1)-bit count.
REQ-029 FLUSH SHALL clear both pointers and COUNT on the edge of the write.
REQ-030 A read concurrent with FLUSH SHALL return the pre-flush head, and the FIFO SHALL then be empty.
REQ-031 FLUSH SHALL take priority over a push.
REQ-032 Clearing ENABLE SHALL stop pushes only; buffered words SHALL remain readable.

Reset
REQ-033 On resetn low, the block SHALL asynchronously clear pointers, COUNT, ENABLE, HERR and the health-test state.
REQ-034 During reset, the outputs SHALL be lfsr_ready=0, reg_dat_wait=reg_dat_re, reg_dat_do=0 and reg_ctrl_do=0.
REQ-035 Reset asserted mid-read SHALL abandon the read.
REQ-036 After reset release, the FIFO SHALL be empty.

Configuration
REQ-037 Macro RNG_FIFO_HEALTH_EN SHALL control a repetition health test.
REQ-038 With RNG_FIFO_HEALTH_EN defined, an accepted word equal to the previously accepted word SHALL be discarded (not stored).
REQ-039 With RNG_FIFO_HEALTH_EN defined, a discarded repeat word SHALL set HERR on that edge.
REQ-040 With RNG_FIFO_HEALTH_EN defined, the compare register SHALL be cleared by reset but SHALL NOT be cleared by FLUSH.
REQ-041 Without RNG_FIFO_HEALTH_EN, every accepted word SHALL be stored, HERR SHALL read 0, and no compare register SHALL exist.

Verification
REQ-042 Scenario fill to full: ENABLE=1 with a valid LFSR stream seeded 32'hBABECAFE -> after 8 pushes, COUNT=8 and lfsr_ready=0; the 9th word is not consumed.
REQ-043 Scenario read order: 8 words are read back -> they match pushed order exactly, COUNT returns to 0, and the next read raises reg_dat_wait.
REQ-044 Scenario stalled read: reg_dat_re held with the FIFO empty and lfsr_valid asserted 3 cycles later -> wait=1 for 4 cycles, then the first pushed word is returned and wait drops.
REQ-045 Scenario flush: FLUSH written with 5 words stored and reg_dat_re=1 in the same cycle -> the old head is returned and COUNT=0 on the next cycle.
REQ-046 Scenario health test with RNG_FIFO_HEALTH_EN: words 32'h1234_5678 and 32'h1234_5678 are pushed -> COUNT=1 and HERR=1; writing 1 to bit 2 gives HERR=0. Without the macro: COUNT=2 and HERR=0.
REQ-047 Scenario async reset: resetn pulsed low mid-stream with 3 words stored -> COUNT=0, ENABLE=0 and lfsr_ready=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/lfsr_rng_fifo.sv
// Random-word FIFO between an upstream LFSR and a CPU register port.
// Define RNG_FIFO_HEALTH_EN to discard back-to-back repeated words and flag them in HERR.
module lfsr_rng_fifo #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] lfsr_data,
  input  logic        lfsr_valid,
  output logic        lfsr_ready,
  input  logic [3:0]  reg_ctrl_we,
  input  logic [31:0] reg_ctrl_di,
  output logic [31:0] reg_ctrl_do,
  input  logic        reg_dat_re,
  output logic [31:0] reg_dat_do,
  output logic        reg_dat_wait
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          enable_q, enable_d;
  logic [31:0]   mem_q [DEPTH];
  logic          full, empty, flush, accept, repeat_hit, push, pop, herr;
  logic          unused_ctrl;

  assign unused_ctrl  = ^{reg_ctrl_we[3:1], reg_ctrl_di[31:2]};
  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign flush        = reg_ctrl_we[0] & reg_ctrl_di[1];
  assign lfsr_ready   = enable_q & ~full & ~flush;
  assign accept       = lfsr_valid & lfsr_ready;
  assign push         = accept & ~repeat_hit;
  assign pop          = reg_dat_re & ~empty;
  assign reg_dat_wait = reg_dat_re & empty;
  assign reg_dat_do   = empty ? 32'h0 : mem_q[rd_ptr_q];
  assign reg_ctrl_do  = {24'h0, 4'(count_q), 1'b0, herr, 1'b0, enable_q};

`ifdef RNG_FIFO_HEALTH_EN
  // Compare register survives FLUSH so a repeat straddling a flush is still caught.
  logic [31:0] prev_q, prev_d;
  logic        prev_vld_q, prev_vld_d, herr_q, herr_d;

  assign repeat_hit = accept & prev_vld_q & (lfsr_data == prev_q);
  assign herr       = herr_q;

  always_comb begin
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    herr_d     = herr_q;
    if (accept) begin
      prev_d     = lfsr_data;
      prev_vld_d = 1'b1;
    end
    if (reg_ctrl_we[0] && reg_ctrl_di[2]) herr_d = 1'b0;
    if (repeat_hit) herr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      herr_q     <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      herr_q     <= herr_d;
    end
  end
`else
  assign repeat_hit = 1'b0;
  assign herr       = 1'b0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    enable_d = enable_q;
    if (reg_ctrl_we[0]) enable_d = reg_ctrl_di[0];
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      enable_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      enable_q <= enable_d;
    end
  end

  // Storage needs no reset: empty masks the read data.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= lfsr_data;
  end
endmodule

// File: tb/tb_lfsr_rng_fifo.sv
// Bench for lfsr_rng_fifo: vector table plus hand sequences, with a queue model of the FIFO.
module tb_lfsr_rng_fifo;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] lfsr_data;
  logic        lfsr_valid;
  logic        lfsr_ready;
  logic [3:0]  reg_ctrl_we;
  logic [31:0] reg_ctrl_di;
  logic [31:0] reg_ctrl_do;
  logic        reg_dat_re;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;

  lfsr_rng_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .lfsr_data(lfsr_data), .lfsr_valid(lfsr_valid),
    .lfsr_ready(lfsr_ready), .reg_ctrl_we(reg_ctrl_we), .reg_ctrl_di(reg_ctrl_di),
    .reg_ctrl_do(reg_ctrl_do), .reg_dat_re(reg_dat_re), .reg_dat_do(reg_dat_do),
    .reg_dat_wait(reg_dat_wait)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        re;
    logic [3:0]  we;
    logic [31:0] di;
    logic        rdy;
    logic        wt;
    logic [3:0]  cnt;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] mq[$];
  logic        m_en, m_herr, m_pv, e_rdy, acc;
  logic [31:0] m_prev, lfsr_w, first;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [31:0] nxt(input logic [31:0] x);
    return {x[30:0], 1'b0} ^ (x[31] ? 32'h0000_00C5 : 32'h0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic re, input logic [3:0] we, input logic [31:0] di,
                     input logic rdy, input logic wt, input logic [3:0] cnt);
    vec_t x;
    x = '{v, re, we, di, rdy, wt, cnt};
    vecs.push_back(x);
  endtask

  task automatic model_reset();
    mq.delete();
    m_en = 1'b0; m_herr = 1'b0; m_pv = 1'b0; m_prev = '0;
  endtask

  // Drive one cycle's inputs and check combinational outputs against the model.
  task automatic drive_check(input logic v, input logic [31:0] d, input logic re,
                             input logic [3:0] we, input logic [31:0] di);
    logic [31:0] e_do;
    lfsr_valid = v; lfsr_data = d; reg_dat_re = re; reg_ctrl_we = we; reg_ctrl_di = di;
    #1;
    e_rdy = m_en && (mq.size() < DEPTH) && !(we[0] && di[1]);
    e_do  = (mq.size() > 0) ? mq[0] : 32'h0;
    chk("ready", 32'(lfsr_ready), 32'(e_rdy));
    chk("wait", 32'(reg_dat_wait), 32'(re && mq.size() == 0));
    chk("rdata", reg_dat_do, e_do);
    chk("ctrl", reg_ctrl_do, {24'h0, 4'(mq.size()), 1'b0, m_herr, 1'b0, m_en});
  endtask

  task automatic clock_model(output logic accepted);
    logic rep;
    @(posedge clk);
    rep = 1'b0;
    if (reg_dat_re && mq.size() > 0) void'(mq.pop_front());
    accepted = lfsr_valid && e_rdy;
    if (reg_ctrl_we[0] && reg_ctrl_di[1]) mq.delete();
`ifdef RNG_FIFO_HEALTH_EN
    if (accepted && m_pv && lfsr_data == m_prev) rep = 1'b1;
    if (accepted) begin m_prev = lfsr_data; m_pv = 1'b1; end
    if (reg_ctrl_we[0] && reg_ctrl_di[2]) m_herr = 1'b0;
    if (rep) m_herr = 1'b1;
`endif
    if (accepted && !rep) mq.push_back(lfsr_data);
    if (reg_ctrl_we[0]) m_en = reg_ctrl_di[0];
    #1;
  endtask

  task automatic stream(input logic v, input logic re, input logic [3:0] we, input logic [31:0] di);
    drive_check(v, lfsr_w, re, we, di);
    clock_model(acc);
    if (acc) lfsr_w = nxt(lfsr_w);
  endtask

  initial begin
    int waits;
    logic done;
    lfsr_w = 32'hBABE_CAFE;
    model_reset();

    // fill to full, 9th word held, read back in order, concurrent push/pop, disable
    add(0, 1, 4'h0, 32'h0, 0, 1, 0);
    add(0, 0, 4'h1, 32'h1, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(1, 0, 4'h0, 32'h0, 1, 0, 4'(i));
    add(1, 0, 4'h0, 32'h0, 0, 0, 8);
    add(1, 0, 4'h0, 32'h0, 0, 0, 8);
    add(0, 1, 4'h0, 32'h0, 0, 0, 8);
    for (int i = 7; i >= 1; i--) add(0, 1, 4'h0, 32'h0, 1, 0, 4'(i));
    add(0, 1, 4'h0, 32'h0, 1, 1, 0);
    add(1, 1, 4'h0, 32'h0, 1, 1, 0);
    add(1, 1, 4'h0, 32'h0, 1, 0, 1);
    add(0, 1, 4'h0, 32'h0, 1, 0, 1);
    add(0, 0, 4'h0, 32'h0, 1, 0, 0);
    add(1, 0, 4'h0, 32'h0, 1, 0, 0);
    add(1, 0, 4'h0, 32'h0, 1, 0, 1);
    add(1, 0, 4'h1, 32'h0, 1, 0, 2);
    add(1, 0, 4'h0, 32'h0, 0, 0, 3);
    add(0, 1, 4'h0, 32'h0, 0, 0, 3);
    add(0, 1, 4'h0, 32'h0, 0, 0, 2);
    add(0, 1, 4'h0, 32'h0, 0, 0, 1);
    add(0, 0, 4'h0, 32'h0, 0, 0, 0);

    // reset values with a read pending
    resetn = 1'b0; lfsr_valid = 1'b1; lfsr_data = 32'h0; reg_dat_re = 1'b1;
    reg_ctrl_we = 4'h0; reg_ctrl_di = 32'h0;
    #12;
    chk("rst_ready", 32'(lfsr_ready), 32'h0);
    chk("rst_wait", 32'(reg_dat_wait), 32'h1);
    chk("rst_rdata", reg_dat_do, 32'h0);
    chk("rst_ctrl", reg_ctrl_do, 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive_check(vecs[i].v, lfsr_w, vecs[i].re, vecs[i].we, vecs[i].di);
      chk($sformatf("vec%0d_ready", i), 32'(lfsr_ready), 32'(vecs[i].rdy));
      chk($sformatf("vec%0d_wait", i), 32'(reg_dat_wait), 32'(vecs[i].wt));
      chk($sformatf("vec%0d_count", i), 32'(reg_ctrl_do[7:4]), 32'(vecs[i].cnt));
      clock_model(acc);
      if (acc) lfsr_w = nxt(lfsr_w);
    end

    // stalled read: valid arrives 3 cycles into the stall
    stream(0, 0, 4'h1, 32'h1);
    first = lfsr_w; waits = 0; done = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      drive_check(i >= 3, lfsr_w, 1, 4'h0, 32'h0);
      if (reg_dat_wait) waits++;
      else begin
        chk("stall_rdata", reg_dat_do, first);
        done = 1'b1;
      end
      clock_model(acc);
      if (acc) lfsr_w = nxt(lfsr_w);
    end
    chk("stall_done", 32'(done), 32'h1);
    chk("stall_waits", 32'(waits), 32'd4);
    for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++) stream(0, 1, 4'h0, 32'h0);

    // flush with 5 stored and a concurrent read
    first = lfsr_w;
    for (int i = 0; i < 5; i++) stream(1, 0, 4'h0, 32'h0);
    drive_check(0, lfsr_w, 1, 4'h1, 32'h3);
    chk("flush_head", reg_dat_do, first);
    chk("flush_count_before", 32'(reg_ctrl_do[7:4]), 32'd5);
    clock_model(acc);
    drive_check(0, lfsr_w, 1, 4'h0, 32'h0);
    chk("flush_count_after", 32'(reg_ctrl_do[7:4]), 32'd0);
    chk("flush_wait_after", 32'(reg_dat_wait), 32'h1);
    clock_model(acc);

    // repeated word
    drive_check(1, 32'h1234_5678, 0, 4'h0, 32'h0); clock_model(acc);
    drive_check(1, 32'h1234_5678, 0, 4'h0, 32'h0); clock_model(acc);
    drive_check(0, 32'h0, 0, 4'h1, 32'h5);
`ifdef RNG_FIFO_HEALTH_EN
    chk("health_count", 32'(reg_ctrl_do[7:4]), 32'd1);
    chk("health_herr", 32'(reg_ctrl_do[2]), 32'h1);
`else
    chk("health_count", 32'(reg_ctrl_do[7:4]), 32'd2);
    chk("health_herr", 32'(reg_ctrl_do[2]), 32'h0);
`endif
    clock_model(acc);
    drive_check(0, 32'h0, 0, 4'h0, 32'h0);
    chk("herr_cleared", 32'(reg_ctrl_do[2]), 32'h0);
    clock_model(acc);
    stream(0, 0, 4'h1, 32'h3);

    // async reset mid-stream, mid-read, between edges
    for (int i = 0; i < 3; i++) stream(1, 0, 4'h0, 32'h0);
    drive_check(0, lfsr_w, 1, 4'h0, 32'h0);
    chk("pre_rst_count", 32'(reg_ctrl_do[7:4]), 32'd3);
    resetn = 1'b0;
    #1;
    model_reset();
    chk("arst_ctrl", reg_ctrl_do, 32'h0);
    chk("arst_ready", 32'(lfsr_ready), 32'h0);
    chk("arst_wait", 32'(reg_dat_wait), 32'h1);
    chk("arst_rdata", reg_dat_do, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    drive_check(1, lfsr_w, 1, 4'h0, 32'h0);
    clock_model(acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
